// File: rtl/cpu7_csr_ctl.sv
// ---------------------------------------------------------------------------
// cpu7_csr_ctl
//
// Execute-stage CSR / exception control for the cpu7 core.  Sequences CSR
// reads, writes and exchanges against the external CSR file, commits
// synchronous exceptions, interrupts and ertn, and redirects fetch for one
// cycle after each exception or ertn.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   valid_e                  instruction in _e is valid
//   csr_op_e                 00 none, 01 csrrd, 10 csrwr, 11 csrxchg
//   csr_num_e                target CSR number
//   rd_data_e / rj_data_e    write data / csrxchg write mask
//   ertn_e, excp_e           ertn and synchronous exception in _e
//   excp_code_e              exception code for excp_e
//   csr_ecl_crmd_ie          global interrupt enable (CRMD.IE)
//   csr_ecl_timer_intr       timer interrupt pending
//   ext_intr                 raw asynchronous external interrupt
//   csr_rdata                read data for csr_raddr
//   csr_eentry, csr_era      exception entry / return address
//   csr_raddr, csr_waddr     CSR read / write address
//   csr_wdata, csr_mask      CSR write data and per-bit write mask
//   csr_wen                  CSR write strobe
//   exu_ifu_except           exception/interrupt commit strobe
//   ecl_csr_ertn_e           ertn commit strobe
//   ecl_csr_exccode_e        committed exception code
//   redirect_vld/pc          fetch redirect
//   csr_res_vld_w/csr_res_w  old CSR value headed for writeback
// ---------------------------------------------------------------------------
module cpu7_csr_ctl #(
   parameter int GRLEN   = 32,
   parameter int CSR_BIT = 14
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               valid_e,
   input  logic [1:0]         csr_op_e,
   input  logic [CSR_BIT-1:0] csr_num_e,
   input  logic [GRLEN-1:0]   rd_data_e,
   input  logic [GRLEN-1:0]   rj_data_e,
   input  logic               ertn_e,
   input  logic               excp_e,
   input  logic [5:0]         excp_code_e,
   input  logic               csr_ecl_crmd_ie,
   input  logic               csr_ecl_timer_intr,
   input  logic               ext_intr,
   input  logic [GRLEN-1:0]   csr_rdata,
   input  logic [GRLEN-1:0]   csr_eentry,
   input  logic [GRLEN-1:0]   csr_era,
   output logic [CSR_BIT-1:0] csr_raddr,
   output logic [CSR_BIT-1:0] csr_waddr,
   output logic [GRLEN-1:0]   csr_wdata,
   output logic [GRLEN-1:0]   csr_mask,
   output logic               csr_wen,
   output logic               exu_ifu_except,
   output logic               ecl_csr_ertn_e,
   output logic [5:0]         ecl_csr_exccode_e,
   output logic               redirect_vld,
   output logic [GRLEN-1:0]   redirect_pc,
   output logic               csr_res_vld_w,
   output logic [GRLEN-1:0]   csr_res_w
);

   localparam logic [CSR_BIT-1:0] CRMD_NUM = '0;

   typedef enum logic [1:0] {
      ST_RUN = 2'd0,
      ST_EXC = 2'd1,
      ST_RET = 2'd2
   } state_t;

   state_t state_q;
   state_t state_nxt;

   logic ext_meta;
   logic ext_sync;
   logic crmd_wr_q;

   logic act;
   logic intr;
   logic take_exc;
   logic take_ertn;
   logic op_go;

   // Two-flop synchronizer for the asynchronous external interrupt line.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ext_meta <= 1'b0;
         ext_sync <= 1'b0;
      end else begin
         ext_meta <= ext_intr;
         ext_sync <= ext_meta;
      end
   end

   // Gating with resetn keeps every strobe quiet while reset is held, even
   // if the upstream pipe still presents a valid instruction.
   assign act = resetn & valid_e & (state_q == ST_RUN);

   // crmd_wr_q masks interrupts for one cycle after a CRMD write, so a
   // freshly written IE value is seen before any interrupt is taken.
   assign intr = act & csr_ecl_crmd_ie
               & (csr_ecl_timer_intr | ext_sync)
               & ~crmd_wr_q;

   assign take_exc  = act & (excp_e | intr);
   assign take_ertn = act & ertn_e & ~take_exc;

   // A CSR op commits only when nothing of higher priority claims the cycle.
   assign op_go = act & (csr_op_e != 2'b00) & ~take_exc & ~ertn_e;

   assign exu_ifu_except    = take_exc;
   assign ecl_csr_ertn_e    = take_ertn;
   assign ecl_csr_exccode_e = excp_e ? excp_code_e : 6'h00;

   assign csr_raddr = csr_num_e;
   assign csr_waddr = csr_num_e;
   assign csr_wdata = rd_data_e;
   assign csr_wen   = op_go & csr_op_e[1];

   always_comb begin
      csr_mask = '0;
      case (csr_op_e)
         2'b10:   csr_mask = '1;
         2'b11:   csr_mask = rj_data_e;
         default: csr_mask = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_nxt;
      end
   end

   // EXC and RET each hold for exactly one cycle; the redirect target is
   // taken from the CSR file in that cycle, after any CSR update landed.
   always_comb begin
      state_nxt    = state_q;
      redirect_vld = 1'b0;
      redirect_pc  = '0;
      case (state_q)
         ST_RUN: begin
            if (take_exc) begin
               state_nxt = ST_EXC;
            end else if (take_ertn) begin
               state_nxt = ST_RET;
            end
         end
         ST_EXC: begin
            redirect_vld = resetn;
            redirect_pc  = csr_eentry;
            state_nxt    = ST_RUN;
         end
         ST_RET: begin
            redirect_vld = resetn;
            redirect_pc  = csr_era;
            state_nxt    = ST_RUN;
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   // Old CSR value is captured in the same cycle as the write, so the
   // writeback stage always sees the pre-write contents.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         csr_res_vld_w <= 1'b0;
         csr_res_w     <= '0;
         crmd_wr_q     <= 1'b0;
      end else begin
         csr_res_vld_w <= op_go;
         if (op_go) begin
            csr_res_w <= csr_rdata;
         end
         crmd_wr_q <= csr_wen & (csr_num_e == CRMD_NUM);
      end
   end

endmodule

// File: tb/tb_cpu7_csr_ctl.sv
// ---------------------------------------------------------------------------
// tb_cpu7_csr_ctl
//
// Directed scenarios for each feature of cpu7_csr_ctl followed by a
// randomized run compared against a cycle-level behavioural model.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_cpu7_csr_ctl;

   localparam int GRLEN   = 32;
   localparam int CSR_BIT = 14;

   logic               clk = 1'b0;
   logic               resetn;
   logic               valid_e;
   logic [1:0]         csr_op_e;
   logic [CSR_BIT-1:0] csr_num_e;
   logic [GRLEN-1:0]   rd_data_e;
   logic [GRLEN-1:0]   rj_data_e;
   logic               ertn_e;
   logic               excp_e;
   logic [5:0]         excp_code_e;
   logic               csr_ecl_crmd_ie;
   logic               csr_ecl_timer_intr;
   logic               ext_intr;
   logic [GRLEN-1:0]   csr_rdata;
   logic [GRLEN-1:0]   csr_eentry;
   logic [GRLEN-1:0]   csr_era;
   logic [CSR_BIT-1:0] csr_raddr;
   logic [CSR_BIT-1:0] csr_waddr;
   logic [GRLEN-1:0]   csr_wdata;
   logic [GRLEN-1:0]   csr_mask;
   logic               csr_wen;
   logic               exu_ifu_except;
   logic               ecl_csr_ertn_e;
   logic [5:0]         ecl_csr_exccode_e;
   logic               redirect_vld;
   logic [GRLEN-1:0]   redirect_pc;
   logic               csr_res_vld_w;
   logic [GRLEN-1:0]   csr_res_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu7_csr_ctl #(.GRLEN(GRLEN), .CSR_BIT(CSR_BIT)) dut (
      .clk                (clk),
      .resetn             (resetn),
      .valid_e            (valid_e),
      .csr_op_e           (csr_op_e),
      .csr_num_e          (csr_num_e),
      .rd_data_e          (rd_data_e),
      .rj_data_e          (rj_data_e),
      .ertn_e             (ertn_e),
      .excp_e             (excp_e),
      .excp_code_e        (excp_code_e),
      .csr_ecl_crmd_ie    (csr_ecl_crmd_ie),
      .csr_ecl_timer_intr (csr_ecl_timer_intr),
      .ext_intr           (ext_intr),
      .csr_rdata          (csr_rdata),
      .csr_eentry         (csr_eentry),
      .csr_era            (csr_era),
      .csr_raddr          (csr_raddr),
      .csr_waddr          (csr_waddr),
      .csr_wdata          (csr_wdata),
      .csr_mask           (csr_mask),
      .csr_wen            (csr_wen),
      .exu_ifu_except     (exu_ifu_except),
      .ecl_csr_ertn_e     (ecl_csr_ertn_e),
      .ecl_csr_exccode_e  (ecl_csr_exccode_e),
      .redirect_vld       (redirect_vld),
      .redirect_pc        (redirect_pc),
      .csr_res_vld_w      (csr_res_vld_w),
      .csr_res_w          (csr_res_w)
   );

   task automatic drive_idle();
      valid_e            = 1'b0;
      csr_op_e           = 2'b00;
      csr_num_e          = '0;
      rd_data_e          = '0;
      rj_data_e          = '0;
      ertn_e             = 1'b0;
      excp_e             = 1'b0;
      excp_code_e        = 6'h00;
      csr_ecl_crmd_ie    = 1'b0;
      csr_ecl_timer_intr = 1'b0;
      ext_intr           = 1'b0;
      csr_rdata          = '0;
      csr_eentry         = '0;
      csr_era            = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      resetn = 1'b1;
      drive_idle();
      #2;
      resetn             = 1'b0;
      valid_e            = 1'b1;
      csr_op_e           = 2'b10;
      excp_e             = 1'b1;
      ertn_e             = 1'b1;
      csr_ecl_crmd_ie    = 1'b1;
      csr_ecl_timer_intr = 1'b1;
      #2;
      checks++; if (csr_wen !== 1'b0) begin errors++; $display("[TB] FAIL rst_wen got %b want 0", csr_wen); end
      checks++; if (exu_ifu_except !== 1'b0) begin errors++; $display("[TB] FAIL rst_except got %b want 0", exu_ifu_except); end
      checks++; if (ecl_csr_ertn_e !== 1'b0) begin errors++; $display("[TB] FAIL rst_ertn got %b want 0", ecl_csr_ertn_e); end
      checks++; if (redirect_vld !== 1'b0) begin errors++; $display("[TB] FAIL rst_redirect got %b want 0", redirect_vld); end
      tick();
      checks++; if (csr_res_vld_w !== 1'b0) begin errors++; $display("[TB] FAIL rst_res_vld got %b want 0", csr_res_vld_w); end
      checks++; if (csr_res_w !== 32'h0) begin errors++; $display("[TB] FAIL rst_res_w got %h want 0", csr_res_w); end
      drive_idle();
      resetn = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_csrxchg();
      $display("[TB] test_csrxchg");
      drive_idle();
      valid_e   = 1'b1;
      csr_op_e  = 2'b11;
      csr_num_e = 14'h6;
      rd_data_e = 32'hFFFF_0000;
      rj_data_e = 32'h00FF_FF00;
      csr_rdata = 32'h1234_5678;
      #1;
      checks++; if (csr_wen !== 1'b1) begin errors++; $display("[TB] FAIL xchg_wen got %b want 1", csr_wen); end
      checks++; if (csr_mask !== 32'h00FF_FF00) begin errors++; $display("[TB] FAIL xchg_mask got %h want 00ffff00", csr_mask); end
      checks++; if (csr_wdata !== 32'hFFFF_0000) begin errors++; $display("[TB] FAIL xchg_wdata got %h want ffff0000", csr_wdata); end
      checks++; if (csr_waddr !== 14'h6 || csr_raddr !== 14'h6) begin errors++; $display("[TB] FAIL xchg_addr got %h/%h want 6/6", csr_raddr, csr_waddr); end
      tick();
      drive_idle();
      #1;
      checks++; if (csr_res_vld_w !== 1'b1) begin errors++; $display("[TB] FAIL xchg_res_vld got %b want 1", csr_res_vld_w); end
      checks++; if (csr_res_w !== 32'h1234_5678) begin errors++; $display("[TB] FAIL xchg_res got %h want 12345678", csr_res_w); end
      tick();
      checks++; if (csr_res_vld_w !== 1'b0) begin errors++; $display("[TB] FAIL xchg_res_pulse got %b want 0", csr_res_vld_w); end
      checks++; if (csr_res_w !== 32'h1234_5678) begin errors++; $display("[TB] FAIL xchg_res_hold got %h want 12345678", csr_res_w); end
      checks++; if (csr_mask !== 32'h0) begin errors++; $display("[TB] FAIL idle_mask got %h want 0", csr_mask); end
      tick();
   endtask

   task automatic test_exception();
      $display("[TB] test_exception");
      drive_idle();
      valid_e     = 1'b1;
      csr_op_e    = 2'b10;
      csr_num_e   = 14'h6;
      rd_data_e   = 32'hCAFE_0001;
      excp_e      = 1'b1;
      excp_code_e = 6'h0E;
      csr_eentry  = 32'h1C00_8000;
      #1;
      checks++; if (exu_ifu_except !== 1'b1) begin errors++; $display("[TB] FAIL exc_strobe got %b want 1", exu_ifu_except); end
      checks++; if (ecl_csr_exccode_e !== 6'h0E) begin errors++; $display("[TB] FAIL exc_code got %h want 0e", ecl_csr_exccode_e); end
      checks++; if (csr_wen !== 1'b0) begin errors++; $display("[TB] FAIL exc_wen got %b want 0", csr_wen); end
      checks++; if (redirect_vld !== 1'b0) begin errors++; $display("[TB] FAIL exc_redirect_early got %b want 0", redirect_vld); end
      tick();
      excp_e = 1'b0;
      #1;
      checks++; if (redirect_vld !== 1'b1) begin errors++; $display("[TB] FAIL exc_redirect got %b want 1", redirect_vld); end
      checks++; if (redirect_pc !== 32'h1C00_8000) begin errors++; $display("[TB] FAIL exc_redirect_pc got %h want 1c008000", redirect_pc); end
      checks++; if (csr_wen !== 1'b0) begin errors++; $display("[TB] FAIL exc_squash_wen got %b want 0", csr_wen); end
      checks++; if (csr_res_vld_w !== 1'b0) begin errors++; $display("[TB] FAIL exc_res_vld got %b want 0", csr_res_vld_w); end
      tick();
      drive_idle();
      #1;
      checks++; if (redirect_vld !== 1'b0) begin errors++; $display("[TB] FAIL exc_one_cycle got %b want 0", redirect_vld); end
      checks++; if (csr_res_vld_w !== 1'b0) begin errors++; $display("[TB] FAIL exc_squash_res got %b want 0", csr_res_vld_w); end
      tick();
   endtask

   task automatic test_ext_intr();
      $display("[TB] test_ext_intr");
      drive_idle();
      valid_e         = 1'b1;
      csr_ecl_crmd_ie = 1'b1;
      csr_eentry      = 32'h1C00_4000;
      tick();
      tick();
      tick();
      ext_intr = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (exu_ifu_except !== (k == 2)) begin
            errors++;
            $display("[TB] FAIL ext_latency cycle %0d got %b want %b", k, exu_ifu_except, (k == 2));
         end
         if (k == 2) begin
            checks++; if (ecl_csr_exccode_e !== 6'h00) begin errors++; $display("[TB] FAIL ext_code got %h want 00", ecl_csr_exccode_e); end
         end
         tick();
      end
      #1;
      checks++; if (exu_ifu_except !== 1'b0) begin errors++; $display("[TB] FAIL ext_in_exc got %b want 0", exu_ifu_except); end
      checks++; if (redirect_pc !== 32'h1C00_4000) begin errors++; $display("[TB] FAIL ext_redirect_pc got %h want 1c004000", redirect_pc); end
      tick();
      csr_ecl_crmd_ie = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         checks++; if (exu_ifu_except !== 1'b0) begin errors++; $display("[TB] FAIL ext_ie0 cycle %0d got %b want 0", k, exu_ifu_except); end
         tick();
      end
      drive_idle();
      tick();
      tick();
      tick();
   endtask

   task automatic test_ertn();
      $display("[TB] test_ertn");
      drive_idle();
      valid_e = 1'b1;
      ertn_e  = 1'b1;
      csr_era = 32'h1C00_0100;
      #1;
      checks++; if (ecl_csr_ertn_e !== 1'b1) begin errors++; $display("[TB] FAIL ertn_strobe got %b want 1", ecl_csr_ertn_e); end
      checks++; if (exu_ifu_except !== 1'b0) begin errors++; $display("[TB] FAIL ertn_except got %b want 0", exu_ifu_except); end
      tick();
      ertn_e    = 1'b0;
      csr_op_e  = 2'b10;
      csr_num_e = 14'h6;
      #1;
      checks++; if (redirect_vld !== 1'b1) begin errors++; $display("[TB] FAIL ertn_redirect got %b want 1", redirect_vld); end
      checks++; if (redirect_pc !== 32'h1C00_0100) begin errors++; $display("[TB] FAIL ertn_redirect_pc got %h want 1c000100", redirect_pc); end
      checks++; if (csr_wen !== 1'b0) begin errors++; $display("[TB] FAIL ret_squash_wen got %b want 0", csr_wen); end
      tick();
      drive_idle();
      #1;
      checks++; if (csr_res_vld_w !== 1'b0) begin errors++; $display("[TB] FAIL ret_squash_res got %b want 0", csr_res_vld_w); end
      checks++; if (redirect_vld !== 1'b0) begin errors++; $display("[TB] FAIL ret_one_cycle got %b want 0", redirect_vld); end
      tick();
   endtask

   task automatic test_crmd_intr();
      $display("[TB] test_crmd_intr");
      drive_idle();
      valid_e            = 1'b1;
      csr_ecl_timer_intr = 1'b1;
      csr_op_e           = 2'b10;
      csr_num_e          = 14'h0;
      rd_data_e          = 32'h0000_0004;
      #1;
      checks++; if (csr_wen !== 1'b1) begin errors++; $display("[TB] FAIL crmd_wen got %b want 1", csr_wen); end
      tick();
      csr_op_e        = 2'b00;
      csr_ecl_crmd_ie = 1'b1;
      #1;
      checks++; if (exu_ifu_except !== 1'b0) begin errors++; $display("[TB] FAIL crmd_suppress got %b want 0", exu_ifu_except); end
      tick();
      #1;
      checks++; if (exu_ifu_except !== 1'b1) begin errors++; $display("[TB] FAIL crmd_taken got %b want 1", exu_ifu_except); end
      tick();
      drive_idle();
      tick();
      // Same sequence against a non-CRMD CSR: nothing suppresses the interrupt.
      valid_e            = 1'b1;
      csr_ecl_timer_intr = 1'b1;
      csr_op_e           = 2'b10;
      csr_num_e          = 14'h6;
      tick();
      csr_op_e        = 2'b00;
      csr_ecl_crmd_ie = 1'b1;
      #1;
      checks++; if (exu_ifu_except !== 1'b1) begin errors++; $display("[TB] FAIL noncrmd_taken got %b want 1", exu_ifu_except); end
      tick();
      drive_idle();
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] old_val;
      logic [31:0] new_val;
      $display("[TB] test_back_to_back");
      old_val = 32'h0000_0011;
      drive_idle();
      valid_e   = 1'b1;
      csr_op_e  = 2'b10;
      csr_num_e = 14'h5;
      rd_data_e = 32'hA5A5_0001;
      csr_rdata = old_val;
      #1;
      checks++; if (csr_wen !== 1'b1) begin errors++; $display("[TB] FAIL b2b_wen got %b want 1", csr_wen); end
      checks++; if (csr_mask !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL b2b_mask got %h want ffffffff", csr_mask); end
      new_val = (old_val & ~32'hFFFF_FFFF) | (32'hA5A5_0001 & 32'hFFFF_FFFF);
      tick();
      csr_op_e  = 2'b01;
      csr_rdata = new_val;
      #1;
      checks++; if (csr_res_vld_w !== 1'b1 || csr_res_w !== old_val) begin errors++; $display("[TB] FAIL b2b_first got %b/%h want 1/%h", csr_res_vld_w, csr_res_w, old_val); end
      checks++; if (csr_wen !== 1'b0 || csr_mask !== 32'h0) begin errors++; $display("[TB] FAIL b2b_rd_nowrite got %b/%h want 0/0", csr_wen, csr_mask); end
      tick();
      drive_idle();
      #1;
      checks++; if (csr_res_vld_w !== 1'b1 || csr_res_w !== new_val) begin errors++; $display("[TB] FAIL b2b_second got %b/%h want 1/%h", csr_res_vld_w, csr_res_w, new_val); end
      tick();
   endtask

   task automatic test_reset_mid_exc();
      $display("[TB] test_reset_mid_exc");
      drive_idle();
      valid_e   = 1'b1;
      csr_op_e  = 2'b01;
      csr_rdata = 32'hDEAD_BEEF;
      tick();
      csr_op_e    = 2'b00;
      excp_e      = 1'b1;
      excp_code_e = 6'h03;
      csr_eentry  = 32'h1C00_2000;
      tick();
      excp_e = 1'b0;
      #1;
      checks++; if (redirect_vld !== 1'b1) begin errors++; $display("[TB] FAIL mid_exc_redirect got %b want 1", redirect_vld); end
      checks++; if (csr_res_w !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL mid_exc_res got %h want deadbeef", csr_res_w); end
      resetn = 1'b0;
      #1;
      checks++; if (redirect_vld !== 1'b0) begin errors++; $display("[TB] FAIL mid_exc_abort got %b want 0", redirect_vld); end
      checks++; if (csr_res_w !== 32'h0) begin errors++; $display("[TB] FAIL mid_exc_res_clr got %h want 0", csr_res_w); end
      tick();
      resetn = 1'b1;
      #1;
      checks++; if (redirect_vld !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_redirect got %b want 0", redirect_vld); end
      checks++; if (csr_res_vld_w !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_res_vld got %b want 0", csr_res_vld_w); end
      csr_op_e  = 2'b10;
      csr_num_e = 14'h6;
      #1;
      checks++; if (csr_wen !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_run got %b want 1", csr_wen); end
      tick();
      drive_idle();
      tick();
   endtask

   task automatic test_random();
      int          pend;
      logic        e1, e2, crmd_blk, res_vld_m;
      logic [31:0] res_m, r, mask_m, pc_m;
      logic        busy, take, intr_m, exc_m, ertn_m, commit_m, wen_m;
      logic [5:0]  code_m;
      $display("[TB] test_random");
      drive_idle();
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      tick();
      pend      = 0;
      e1        = 1'b0;
      e2        = 1'b0;
      crmd_blk  = 1'b0;
      res_vld_m = 1'b0;
      res_m     = 32'h0;
      for (int n = 0; n < 400; n++) begin
         valid_e            = ($urandom_range(0, 3) != 0);
         r                  = $urandom;
         csr_op_e           = r[1:0];
         r                  = $urandom;
         csr_num_e          = ($urandom_range(0, 3) == 0) ? 14'h0 : r[13:0];
         rd_data_e          = $urandom;
         rj_data_e          = $urandom;
         ertn_e             = ($urandom_range(0, 6) == 0);
         excp_e             = ($urandom_range(0, 9) == 0);
         r                  = $urandom;
         excp_code_e        = r[5:0];
         csr_ecl_crmd_ie    = ($urandom_range(0, 1) == 1);
         csr_ecl_timer_intr = ($urandom_range(0, 4) == 0);
         ext_intr           = ($urandom_range(0, 2) == 0);
         csr_rdata          = $urandom;
         csr_eentry         = $urandom;
         csr_era            = $urandom;
         #1;
         busy     = (pend != 0);
         take     = valid_e && !busy;
         intr_m   = take && csr_ecl_crmd_ie && (csr_ecl_timer_intr || e2) && !crmd_blk;
         exc_m    = take && (excp_e || intr_m);
         ertn_m   = take && ertn_e && !exc_m;
         commit_m = take && (csr_op_e != 2'b00) && !exc_m && !ertn_e;
         wen_m    = commit_m && (csr_op_e == 2'b10 || csr_op_e == 2'b11);
         mask_m   = (csr_op_e == 2'b10) ? 32'hFFFF_FFFF : (csr_op_e == 2'b11) ? rj_data_e : 32'h0;
         pc_m     = (pend == 1) ? csr_eentry : csr_era;
         code_m   = excp_e ? excp_code_e : 6'h00;
         checks++; if (exu_ifu_except !== exc_m) begin errors++; $display("[TB] FAIL rnd_except n=%0d got %b want %b", n, exu_ifu_except, exc_m); end
         checks++; if (ecl_csr_ertn_e !== ertn_m) begin errors++; $display("[TB] FAIL rnd_ertn n=%0d got %b want %b", n, ecl_csr_ertn_e, ertn_m); end
         checks++; if (ecl_csr_exccode_e !== code_m) begin errors++; $display("[TB] FAIL rnd_code n=%0d got %h want %h", n, ecl_csr_exccode_e, code_m); end
         checks++; if (csr_wen !== wen_m) begin errors++; $display("[TB] FAIL rnd_wen n=%0d got %b want %b", n, csr_wen, wen_m); end
         checks++; if (csr_mask !== mask_m) begin errors++; $display("[TB] FAIL rnd_mask n=%0d got %h want %h", n, csr_mask, mask_m); end
         checks++; if (csr_wdata !== rd_data_e) begin errors++; $display("[TB] FAIL rnd_wdata n=%0d got %h want %h", n, csr_wdata, rd_data_e); end
         checks++; if (csr_raddr !== csr_num_e || csr_waddr !== csr_num_e) begin errors++; $display("[TB] FAIL rnd_addr n=%0d got %h/%h want %h", n, csr_raddr, csr_waddr, csr_num_e); end
         checks++; if (redirect_vld !== busy) begin errors++; $display("[TB] FAIL rnd_redirect n=%0d got %b want %b", n, redirect_vld, busy); end
         if (busy) begin
            checks++; if (redirect_pc !== pc_m) begin errors++; $display("[TB] FAIL rnd_pc n=%0d got %h want %h", n, redirect_pc, pc_m); end
         end
         checks++; if (csr_res_vld_w !== res_vld_m) begin errors++; $display("[TB] FAIL rnd_res_vld n=%0d got %b want %b", n, csr_res_vld_w, res_vld_m); end
         checks++; if (csr_res_w !== res_m) begin errors++; $display("[TB] FAIL rnd_res n=%0d got %h want %h", n, csr_res_w, res_m); end
         res_vld_m = commit_m;
         if (commit_m) res_m = csr_rdata;
         crmd_blk = wen_m && (csr_num_e == 14'h0);
         pend     = exc_m ? 1 : (ertn_m ? 2 : 0);
         e2       = e1;
         e1       = ext_intr;
         tick();
      end
      drive_idle();
      tick();
   endtask

   initial begin
      test_reset();
      test_csrxchg();
      test_exception();
      test_ext_intr();
      test_ertn();
      test_crmd_intr();
      test_back_to_back();
      test_reset_mid_exc();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu7_csr_ctl.md
CPU7_CSR_CTL -- requirements
Module: cpu7_csr_ctl

Interface
REQ-001 SHALL have parameter GRLEN, default 32: data/address width.
REQ-002 SHALL have parameter CSR_BIT, default 14: CSR number width.
REQ-003 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-004 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port valid_e, input, 1: instruction in _e stage is valid.
REQ-006 SHALL have port csr_op_e, input, 2: 00 none, 01 csrrd, 10 csrwr, 11 csrxchg.
REQ-007 SHALL have port csr_num_e, input, CSR_BIT: target CSR number.
REQ-008 SHALL have port rd_data_e, input, GRLEN: CSR write data.
REQ-009 SHALL have port rj_data_e, input, GRLEN: csrxchg write mask.
REQ-010 SHALL have port ertn_e, input, 1: ertn in _e.
REQ-011 SHALL have port excp_e, input, 1: synchronous exception in _e.
REQ-012 SHALL have port excp_code_e, input, 6: exception code.
REQ-013 SHALL have ports csr_ecl_crmd_ie, csr_ecl_timer_intr, ext_intr, input, 1 each: interrupt enable, timer pending, raw external interrupt.
REQ-014 SHALL have ports csr_rdata, csr_eentry, csr_era, input, GRLEN each: values returned by the CSR file.
REQ-015 SHALL have ports csr_raddr, csr_waddr, output, CSR_BIT each: CSR read/write address.
REQ-016 SHALL have ports csr_wdata, csr_mask, output, GRLEN each: write data and bit mask.
REQ-017 SHALL have port csr_wen, output, 1: CSR write strobe.
REQ-018 SHALL have ports exu_ifu_except, ecl_csr_ertn_e, output, 1 each: exception/ertn commit strobes.
REQ-019 SHALL have port ecl_csr_exccode_e, output, 6: committed exception code.
REQ-020 SHALL have ports redirect_vld, output, 1, and redirect_pc, output, GRLEN: fetch redirect.
REQ-021 SHALL have ports csr_res_vld_w, output, 1, and csr_res_w, output, GRLEN: old CSR value to writeback.

Function
REQ-022 SHALL synchronize ext_intr through 2 flops; ext_sync is used for all decisions (2-cycle latency).
REQ-023 SHALL implement FSM RUN, EXC, RET; EXC/RET each last exactly 1 cycle, then return to RUN.
REQ-024 SHALL define act = valid_e & state==RUN; in EXC/RET, valid_e is squashed (no strobe, no CSR write).
REQ-025 SHALL define intr = act & csr_ecl_crmd_ie & (csr_ecl_timer_intr | ext_sync).
REQ-026 SHALL prioritise, in one cycle: excp_e > intr > ertn_e > CSR op.
REQ-027 SHALL assert exu_ifu_except combinationally when act & (excp_e | intr); ecl_csr_exccode_e = excp_code_e if excp_e, else 6'h0; state -> EXC.
REQ-028 SHALL assert ecl_csr_ertn_e when act & ertn_e & no exception/interrupt; state -> RET.
REQ-029 SHALL, in EXC, drive redirect_vld=1, redirect_pc=csr_eentry; in RET, redirect_vld=1, redirect_pc=csr_era (sampled in that cycle, after CSR update).
REQ-030 SHALL drive csr_raddr = csr_waddr = csr_num_e at all times.
REQ-031 SHALL drive csr_wdata=rd_data_e; csr_mask = all ones for csrwr, rj_data_e for csrxchg, 0 otherwise.
REQ-032 SHALL assert csr_wen only when act & csr_op_e[1] & no exception/interrupt/ertn.
REQ-033 SHALL, for any non-squashed CSR op (01/10/11), register csr_rdata into csr_res_w and pulse csr_res_vld_w one cycle later (read-before-write: old value).
REQ-034 SHALL hold csr_res_w when no CSR op; csr_res_vld_w is a 1-cycle pulse.
REQ-035 SHALL suppress intr in the cycle immediately after a CSR write to CRMD (14'h0) so IE changes take effect first.
REQ-036 SHALL not block back-to-back CSR ops; a read of a CSR written in the previous cycle returns the new value.

Reset
REQ-037 SHALL on resetn=0 asynchronously set state=RUN, sync flops=0, csr_res_w=0, csr_res_vld_w=0, CRMD-write flag=0.
REQ-038 SHALL output redirect_vld=0, csr_wen=0, exu_ifu_except=0, ecl_csr_ertn_e=0 during reset; reset mid-EXC aborts redirect.

Verification
REQ-039 SHALL verify: csrxchg num=0x6, rd=0xFFFF_0000, rj=0x00FF_FF00, csr_rdata=0x1234_5678 -> csr_wen=1, mask=0x00FF_FF00; next cycle csr_res_vld_w=1, csr_res_w=0x1234_5678.
REQ-040 SHALL verify: excp_e=1 code=0x0E with csrwr same cycle -> exu_ifu_except=1, exccode=0x0E, csr_wen=0; next cycle redirect_vld=1, redirect_pc=csr_eentry.
REQ-041 SHALL verify: ext_intr rises, IE=1, valid_e held -> except asserted exactly 2 cycles later with exccode 0; with IE=0 -> never.
REQ-042 SHALL verify: ertn_e with csr_era=0x1C00_0100 -> ertn strobe; next cycle redirect_pc=0x1C00_0100; valid_e in RET cycle squashed.
REQ-043 SHALL verify: timer pending, csrwr CRMD in cycle N -> no interrupt in N+1; interrupt taken N+2 if IE written 1.
REQ-044 SHALL verify: resetn low during EXC -> redirect_vld=0 immediately; after release state RUN, outputs at reset values.
